// File: rtl/instr_decoder_pipe.sv
// instr_decoder_pipe: pipelined decoder for the 16-bit RISC core.
// The decoded fields sit in a single output register. A one-entry skid
// buffer lets the upstream handshake be registered. A load-use interlock
// inserts one bubble when the next instruction reads the register that a
// LOAD leaving the stage will write.
//
// Instruction layout (MSB first): opcode[4] | selD[RA_W] | aluflag |
// selA[RA_W] | selB[RA_W] | 2 spare bits. The low IMM_W bits double as the
// immediate, so selA/selB/spare overlap the immediate field.
module instr_decoder_pipe #(
    parameter int INSTR_W = 16,
    parameter int RA_W    = 3,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         aluop,
    output logic               aluflag,
    output logic [RA_W-1:0]    selD,
    output logic [RA_W-1:0]    selA,
    output logic [RA_W-1:0]    selB,
    output logic [DATA_W-1:0]  imm,
    output logic               regwe,
    output logic               is_mem,
    output logic               is_branch
);
    localparam int IMM_W = INSTR_W - 4 - RA_W - 1;

    localparam logic [3:0] OP_LI     = 4'h8;
    localparam logic [3:0] OP_JUMP   = 4'hC;
    localparam logic [3:0] OP_JUMPEQ = 4'hD;
    localparam logic [3:0] OP_LOAD   = 4'hE;
    localparam logic [3:0] OP_STORE  = 4'hF;

    typedef struct packed {
        logic [3:0]        aluop;
        logic              aluflag;
        logic [RA_W-1:0]   selD;
        logic [RA_W-1:0]   selA;
        logic [RA_W-1:0]   selB;
        logic [DATA_W-1:0] imm;
        logic              regwe;
        logic              is_mem;
        logic              is_branch;
    } dec_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op <= 4'h7) || (op >= 4'h9 && op <= 4'hB);
    endfunction

    function automatic dec_t decode(input logic [INSTR_W-1:0] w);
        dec_t             d;
        logic [IMM_W-1:0] lo;
        lo        = w[IMM_W-1:0];
        d.aluop   = w[INSTR_W-1 -: 4];
        d.selD    = w[INSTR_W-5 -: RA_W];
        d.aluflag = w[INSTR_W-5-RA_W];
        d.selA    = w[2*RA_W+1 -: RA_W];
        d.selB    = w[RA_W+1 -: RA_W];
        // LI either zero-extends or parks the immediate in the top bits
        if (d.aluop == OP_LI)
            d.imm = d.aluflag ? (DATA_W'(lo) << (DATA_W - IMM_W)) : DATA_W'(lo);
        else
            d.imm = DATA_W'($signed(lo));
        d.regwe     = is_alu(d.aluop) || d.aluop == OP_LI || d.aluop == OP_LOAD;
        d.is_mem    = (d.aluop == OP_LOAD) || (d.aluop == OP_STORE);
        d.is_branch = (d.aluop == OP_JUMP) || (d.aluop == OP_JUMPEQ);
        return d;
    endfunction

    dec_t               dec_q;
    dec_t               cand_dec;
    logic               out_valid_q;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [INSTR_W-1:0] cand_instr;
    logic               in_beat;
    logic               out_beat;
    logic               out_free;
    logic               cand_valid;
    logic               use_a;
    logic               use_b;
    logic               hazard;
    logic               load_out;

    // in_ready is the registered "skid empty" flag, gated off while frozen
    assign in_ready   = en && !skid_valid;
    assign in_beat    = in_valid && in_ready;
    assign out_beat   = out_valid_q && out_ready && en;
    assign out_free   = !out_valid_q || out_ready;

    // The skid entry is always older than the live input, so it goes first
    assign cand_instr = skid_valid ? skid_instr : instr;
    assign cand_valid = skid_valid || in_beat;
    assign cand_dec   = decode(cand_instr);

    // Load-use check: does the next instruction read the departing LOAD's destination
    always_comb begin
        use_a  = (cand_dec.aluop != OP_LI) && (cand_dec.aluop != OP_JUMP);
        use_b  = is_alu(cand_dec.aluop) || cand_dec.aluop == OP_JUMPEQ ||
                 cand_dec.aluop == OP_STORE;
        hazard = out_beat && (dec_q.aluop == OP_LOAD) && cand_valid &&
                 ((use_a && cand_dec.selA == dec_q.selD) ||
                  (use_b && cand_dec.selB == dec_q.selD));
    end

    assign load_out = out_free && cand_valid && !hazard;

    // Output register and skid buffer; a hazard leaves the output empty for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
        end else if (en) begin
            if (flush) begin
                out_valid_q <= 1'b0;
                skid_valid  <= 1'b0;
            end else begin
                if (out_free) begin
                    out_valid_q <= load_out;
                    if (load_out)
                        dec_q <= cand_dec;
                end
                if (skid_valid) begin
                    if (load_out)
                        skid_valid <= 1'b0;
                end else if (in_beat && !load_out) begin
                    skid_valid <= 1'b1;
                    skid_instr <= instr;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign aluop     = dec_q.aluop;
    assign aluflag   = dec_q.aluflag;
    assign selD      = dec_q.selD;
    assign selA      = dec_q.selA;
    assign selB      = dec_q.selB;
    assign imm       = dec_q.imm;
    assign regwe     = dec_q.regwe;
    assign is_mem    = dec_q.is_mem;
    assign is_branch = dec_q.is_branch;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Testbench for instr_decoder_pipe: decode table, hand-written handshake,
// interlock, flush and freeze sequences, then randomized traffic against a
// queue-based reference model.
module tb_instr_decoder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic [15:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  aluop;
    logic        aluflag;
    logic [2:0]  selD;
    logic [2:0]  selA;
    logic [2:0]  selB;
    logic [15:0] imm;
    logic        regwe;
    logic        is_mem;
    logic        is_branch;

    int n_chk  = 0;
    int n_fail = 0;

    instr_decoder_pipe dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .instr(instr),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .aluop(aluop), .aluflag(aluflag), .selD(selD),
        .selA(selA), .selB(selB), .imm(imm), .regwe(regwe), .is_mem(is_mem),
        .is_branch(is_branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [32:0] exp;
    } vec_t;

    function automatic logic [32:0] mk(input int op, input int fl, input int sd, input int sa,
                                        input int sb, input int im, input int we, input int mem,
                                        input int br);
        return {op[3:0], fl[0], sd[2:0], sa[2:0], sb[2:0], im[15:0], we[0], mem[0], br[0]};
    endfunction

    // Reference decode computed from the field rules with plain arithmetic
    function automatic logic [32:0] ref_dec(input int w);
        int op, sd, fl, sa, sb, lo, im, we, mem, br;
        op = w / 4096;  sd = (w / 512) % 8;  fl = (w / 256) % 2;
        sa = (w / 32) % 8;  sb = (w / 4) % 8;  lo = w % 256;
        if (op == 8) im = fl ? lo * 256 : lo;
        else         im = (lo >= 128) ? lo + 65280 : lo;
        we  = (op < 8 || (op >= 9 && op <= 11) || op == 8 || op == 14) ? 1 : 0;
        mem = (op >= 14) ? 1 : 0;
        br  = (op == 12 || op == 13) ? 1 : 0;
        return mk(op, fl, sd, sa, sb, im, we, mem, br);
    endfunction

    function automatic bit reads(input int w, input int r);
        int op, sa, sb;
        bit ua, ub;
        op = w / 4096;  sa = (w / 32) % 8;  sb = (w / 4) % 8;
        ua = (op != 8) && (op != 12);
        ub = (op < 8) || (op >= 9 && op <= 11) || op == 13 || op == 15;
        return (ua && sa == r) || (ub && sb == r);
    endfunction

    function automatic logic [32:0] dut_pack();
        return {aluop, aluflag, selD, selA, selB, imm, regwe, is_mem, is_branch};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
    endtask

    vec_t        tbl[10];
    logic [15:0] pend[$];
    logic [33:0] held;
    int          exp_kind;
    int          w, rd;
    bit          was_load, ib, ob;

    initial begin
        tbl[0] = '{16'h1704, mk(1, 1, 3, 0, 1, 'h0004, 1, 0, 0)};
        tbl[1] = '{16'h8EAB, mk(8, 0, 7, 5, 2, 'h00AB, 1, 0, 0)};
        tbl[2] = '{16'h89AB, mk(8, 1, 4, 5, 2, 'hAB00, 1, 0, 0)};
        tbl[3] = '{16'h2080, mk(2, 0, 0, 4, 0, 'hFF80, 1, 0, 0)};
        tbl[4] = '{16'hF07F, mk(15, 0, 0, 3, 7, 'h007F, 0, 1, 0)};
        tbl[5] = '{16'hC123, mk(12, 1, 0, 1, 0, 'h0023, 0, 0, 1)};
        tbl[6] = '{16'hD0FF, mk(13, 0, 0, 7, 7, 'hFFFF, 0, 0, 1)};
        tbl[7] = '{16'h9A80, mk(9, 0, 5, 4, 0, 'hFF80, 1, 0, 0)};
        tbl[8] = '{16'hB7F0, mk(11, 1, 3, 7, 4, 'hFFF0, 1, 0, 0)};
        tbl[9] = '{16'hE400, mk(14, 0, 2, 0, 0, 'h0000, 1, 1, 0)};

        // Reset with en low and flush high: reset must still win
        rst = 1'b1; en = 1'b0; flush = 1'b1; in_valid = 1'b1; instr = 16'hFFFF; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fields", dut_pack(), 0);

        // Decode table, one instruction at a time
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; instr = tbl[i].w;
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_fields", i), dut_pack(), tbl[i].exp);
        end

        // Four instructions with out_ready low for three cycles
        idle();
        out_ready = 1'b0; in_valid = 1'b1; instr = 16'h1704;
        step();
        chk("stall_o0", dut_pack(), ref_dec(16'h1704));
        chk("stall_rdy0", in_ready, 1);
        instr = 16'h2080;
        step();
        chk("stall_o1", dut_pack(), ref_dec(16'h1704));
        chk("stall_rdy1", in_ready, 0);
        instr = 16'h9A80;
        step();
        chk("stall_o2", {out_valid, dut_pack()}, {1'b1, ref_dec(16'h1704)});
        chk("stall_rdy2", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("stall_o3", dut_pack(), ref_dec(16'h2080));
        chk("stall_rdy3", in_ready, 1);
        step();
        chk("stall_o4", {out_valid, dut_pack()}, {1'b1, ref_dec(16'h9A80)});
        instr = 16'hC123;
        step();
        chk("stall_o5", {out_valid, dut_pack()}, {1'b1, ref_dec(16'hC123)});
        in_valid = 1'b0;
        step();
        chk("stall_empty", out_valid, 0);

        // Load-use: dependent ADD gets one bubble
        idle();
        in_valid = 1'b1; instr = 16'hE400;
        step();
        chk("lu_load", {out_valid, dut_pack()}, {1'b1, ref_dec(16'hE400)});
        instr = 16'h0040;
        step();
        chk("lu_bubble", out_valid, 0);
        chk("lu_bubble_rdy", in_ready, 0);
        in_valid = 1'b0;
        step();
        chk("lu_dep", {out_valid, dut_pack()}, {1'b1, ref_dec(16'h0040)});
        step();
        chk("lu_done", out_valid, 0);
        // Independent reader of r3: no bubble
        in_valid = 1'b1; instr = 16'hE400;
        step();
        instr = 16'h0060;
        step();
        chk("lu_indep", {out_valid, dut_pack()}, {1'b1, ref_dec(16'h0060)});
        // Back-to-back LOADs, each checked
        instr = 16'hE400;
        step();
        instr = 16'hE440;
        step();
        chk("lu_ll_bubble1", out_valid, 0);
        instr = 16'h0040;
        step();
        chk("lu_ll_load2", {out_valid, dut_pack()}, {1'b1, ref_dec(16'hE440)});
        step();
        chk("lu_ll_bubble2", out_valid, 0);
        in_valid = 1'b0;
        step();
        chk("lu_ll_dep", {out_valid, dut_pack()}, {1'b1, ref_dec(16'h0040)});

        // Flush with output and skid both full
        idle();
        out_ready = 1'b0; in_valid = 1'b1; instr = 16'h1704;
        step();
        instr = 16'h2080;
        step();
        chk("fl_full_rdy", in_ready, 0);
        flush = 1'b1; instr = 16'h9A80;
        step();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
        flush = 1'b1; instr = 16'hC123; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drop0", out_valid, 0);
        step();
        chk("fl_drop1", out_valid, 0);

        // en low freezes state and ignores flush
        idle();
        out_ready = 1'b0; in_valid = 1'b1; instr = 16'h1704;
        step();
        en = 1'b0; out_ready = 1'b1; flush = 1'b1; instr = 16'h2080;
        #1;
        chk("en_rdy_now", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("en_hold%0d", i), {out_valid, dut_pack()}, {1'b1, ref_dec(16'h1704)});
            chk($sformatf("en_rdy%0d", i), in_ready, 0);
        end
        en = 1'b1; flush = 1'b0;
        #1;
        chk("en_rdy_back", in_ready, 1);
        step();
        chk("en_resume", {out_valid, dut_pack()}, {1'b1, ref_dec(16'h2080)});
        in_valid = 1'b0;
        idle();

        // Randomized traffic against the queue model, then a forced drain
        pend.delete();
        exp_kind = 0;
        for (int cyc = 0; cyc < 2040; cyc++) begin
            @(posedge clk);
            #1;
            if (exp_kind == 1) chk("rnd_invalid", out_valid, 0);
            if (exp_kind == 2) chk("rnd_valid", out_valid, 1);
            if (exp_kind == 3) chk("rnd_hold", {out_valid, dut_pack()}, held);
            if (cyc < 2000) begin
                en        = ($urandom_range(0, 9) != 0);
                flush     = ($urandom_range(0, 49) == 0);
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
                w = $urandom_range(0, 65535);
                if ($urandom_range(0, 3) == 0) w = (w % 4096) + 'hE000;
                instr = w[15:0];
            end else begin
                en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            end
            #1;
            if (!en) chk("rnd_rdy_en", in_ready, 0);
            ib = in_valid && in_ready && en;
            ob = out_valid && out_ready && en;
            exp_kind = 0;
            if (!en) begin
                exp_kind = 3;
                held = {out_valid, dut_pack()};
            end else if (flush) begin
                pend.delete();
                exp_kind = 1;
            end else begin
                was_load = 1'b0;
                rd = 0;
                if (ob) begin
                    if (pend.size() == 0) begin
                        chk("rnd_spurious", 1, 0);
                    end else begin
                        w = pend.pop_front();
                        chk("rnd_data", dut_pack(), ref_dec(w));
                        was_load = (w / 4096) == 14;
                        rd = (w / 512) % 8;
                    end
                end
                if (ib) pend.push_back(instr);
                if (ob || !out_valid) begin
                    if (pend.size() == 0) exp_kind = 1;
                    else if (ob && was_load && reads(pend[0], rd)) exp_kind = 1;
                    else exp_kind = 2;
                end else begin
                    exp_kind = 3;
                    held = {out_valid, dut_pack()};
                end
            end
        end
        chk("rnd_drained", pend.size(), 0);
        chk("rnd_final_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
